// File: rtl/qspi2sdram_pkg.sv
// Shared constants and FSM encoding for the QSPI-to-SDRAM prefetch path.
// The QSPI read front-end also uses BURST_LEN/RAM_AW to size the prefetch RAM.
package qspi2sdram_pkg;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int RAM_AW    = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/qspi_sdram_prefetch_toggle_sync.sv
// Three-flop toggle-to-pulse synchroniser. A level change on tgl_i becomes a
// single-cycle evt_o pulse in the clk_i domain two to three cycles later.
// Also intended for carrying the done indication back to the QSPI side.
module toggle_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tgl_i,
    output logic evt_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 resolve metastability, s3 holds the previous settled level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tgl_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign evt_o = s2_q ^ s3_q;

endmodule

// File: rtl/qspi_sdram_prefetch.sv
// Prefetch filler: turns each synchronised QSPI prefetch request into one
// SDRAM burst read and streams the returned words into the prefetch RAM.
// A request arriving mid-burst is remembered and issued right after the
// current burst finishes, because the controller cannot cancel a burst.
module qspi_sdram_prefetch
    import qspi2sdram_pkg::*;
#(
    parameter int ADDR_W    = qspi2sdram_pkg::ADDR_W,
    parameter int DATA_W    = qspi2sdram_pkg::DATA_W,
    parameter int BURST_LEN = qspi2sdram_pkg::BURST_LEN,
    parameter int TIMEOUT   = 1023
) (
    input  logic                         sd_clk,
    input  logic                         rst,
    input  logic                         qspi_rd_req_tgl,
    input  logic [ADDR_W-1:0]            qspi_rd_addr,
    output logic                         sd_rd_req,
    output logic [ADDR_W-1:0]            sd_rd_addr,
    input  logic                         sd_rd_ack,
    input  logic                         sd_rd_valid,
    input  logic [DATA_W-1:0]            sd_rd_data,
    output logic                         ram_wen,
    output logic [$clog2(BURST_LEN)-1:0] ram_waddr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic                         fill_busy,
    output logic                         fill_done,
    output logic                         fill_err
);

    localparam int WCNT_W = $clog2(BURST_LEN);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    fill_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [WCNT_W-1:0]   wcnt_q,  wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q,  tcnt_d;
    logic                pend_q,  pend_d;
    logic                req_evt;

    toggle_sync u_req_sync (
        .clk_i (sd_clk),
        .rst_i (rst),
        .tgl_i (qspi_rd_req_tgl),
        .evt_o (req_evt)
    );

    // State, captured address, counters and the pending-request flag
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
        end
    end

    // Burst sequencing: next state, counters and all outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = req_evt ? qspi_rd_addr : addr_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        pend_d     = pend_q;
        sd_rd_req  = 1'b0;
        sd_rd_addr = '0;
        ram_wen    = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        fill_err   = 1'b0;

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (req_evt) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                sd_rd_req  = 1'b1;
                sd_rd_addr = addr_q;
                fill_busy  = 1'b1;
                if (sd_rd_ack) begin
                    state_d = DATA;
                    wcnt_d  = '0;
                    tcnt_d  = '0;
                    if (req_evt) begin
                        pend_d = 1'b1;
                    end
                end
            end

            DATA: begin
                fill_busy = 1'b1;
                if (req_evt) begin
                    pend_d = 1'b1;
                end
                if (sd_rd_valid) begin
                    ram_wen   = 1'b1;
                    ram_waddr = wcnt_q;
                    ram_wdata = sd_rd_data;
                    wcnt_d    = wcnt_q + 1'b1;
                    tcnt_d    = '0;
                    if (wcnt_q == WCNT_W'(BURST_LEN - 1)) begin
                        state_d = DONE;
                    end
                end else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
                    fill_err = 1'b1;
                    state_d  = (pend_q || req_evt) ? REQ : IDLE;
                    pend_d   = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            DONE: begin
                fill_done = 1'b1;
                state_d   = (pend_q || req_evt) ? REQ : IDLE;
                pend_d    = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
